// File: rtl/evg_event_arbiter.sv
// evg_event_arbiter: per-source event FIFOs drained round-robin into one registered event stream.
module evg_event_arbiter #(
  parameter int NREQ = 4,
  parameter int EVENTCODE_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter logic [EVENTCODE_WIDTH-1:0] NULL_EVENT_CODE = '0
) (
  input  logic                            evgTxClk,
  input  logic                            evgTxRst_n,
  input  logic [NREQ*EVENTCODE_WIDTH-1:0] reqTDATA,
  input  logic [NREQ-1:0]                 reqTVALID,
  output logic [EVENTCODE_WIDTH-1:0]      evgEventTDATA,
  output logic                            evgEventTVALID,
  input  logic                            evgEventTREADY,
  input  logic                            clearStatus,
  output logic [NREQ-1:0]                 overflow,
  output logic [15:0]                     eventsForwarded,
  output logic [15:0]                     eventsDropped
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(NREQ);
  localparam int EW = EVENTCODE_WIDTH;
  logic [EW-1:0] mem_q [NREQ][FIFO_DEPTH];
  logic [EW-1:0] mem_d [NREQ][FIFO_DEPTH];
  logic [AW:0] wr_q [NREQ];
  logic [AW:0] wr_d [NREQ];
  logic [AW:0] rd_q [NREQ];
  logic [AW:0] rd_d [NREQ];
  logic [IW-1:0] ptr_q, ptr_d, gnt;
  logic [EW-1:0] data_q, data_d;
  logic valid_q, valid_d, load, found;
  logic [NREQ-1:0] ovf_q, ovf_d, nonempty, full, push, pop, drop;
  logic [15:0] fwd_q, fwd_d, drp_q, drp_d;
  logic [16:0] drp_sum;
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      nonempty[i] = wr_q[i] != rd_q[i];
      full[i] = (wr_q[i][AW] != rd_q[i][AW]) && (wr_q[i][AW-1:0] == rd_q[i][AW-1:0]);
    end
    gnt = ptr_q;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && nonempty[(int'(ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        gnt = IW'((int'(ptr_q) + k) % NREQ);
      end
    end
    load = (!valid_q || evgEventTREADY) && found;
    pop = '0;
    pop[gnt] = load;
    mem_d = mem_q;
    wr_d = wr_q;
    rd_d = rd_q;
    // a full FIFO still accepts a push in the cycle its head is popped
    for (int i = 0; i < NREQ; i++) begin
      push[i] = reqTVALID[i] && (reqTDATA[i*EW +: EW] != NULL_EVENT_CODE);
      drop[i] = push[i] && full[i] && !pop[i];
      if (push[i] && !drop[i]) begin
        mem_d[i][wr_q[i][AW-1:0]] = reqTDATA[i*EW +: EW];
        wr_d[i] = wr_q[i] + 1'b1;
      end
      if (pop[i]) rd_d[i] = rd_q[i] + 1'b1;
    end
    data_d = load ? mem_q[gnt][rd_q[gnt][AW-1:0]] : data_q;
    valid_d = load || (valid_q && !evgEventTREADY);
    ptr_d = load ? gnt : ptr_q;
    ovf_d = clearStatus ? '0 : (ovf_q | drop);
    fwd_d = clearStatus ? '0 : fwd_q + {15'd0, valid_q && evgEventTREADY};
    drp_sum = {1'b0, drp_q} + 17'($countones(drop));
    drp_d = clearStatus ? '0 : (drp_sum[16] ? 16'hFFFF : drp_sum[15:0]);
  end
  always_ff @(posedge evgTxClk) mem_q <= mem_d;
  always_ff @(posedge evgTxClk or negedge evgTxRst_n) begin
    if (!evgTxRst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        wr_q[i] <= '0;
        rd_q[i] <= '0;
      end
      ptr_q <= IW'(NREQ - 1);
      data_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= '0;
      fwd_q <= '0;
      drp_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      ptr_q <= ptr_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
      fwd_q <= fwd_d;
      drp_q <= drp_d;
    end
  end
  assign evgEventTDATA = data_q;
  assign evgEventTVALID = valid_q;
  assign overflow = ovf_q;
  assign eventsForwarded = fwd_q;
  assign eventsDropped = drp_q;
endmodule

// File: tb/tb_evg_event_arbiter.sv
// tb_evg_event_arbiter: vector table, directed corner sequences and a queue-based random reference.
module tb_evg_event_arbiter;
  localparam int NREQ = 4;
  localparam int DEPTH = 4;
  logic clk, rst_n, rdy, clr, o_valid;
  logic [31:0] req_d;
  logic [3:0] req_v, ovf;
  logic [7:0] o_data;
  logic [15:0] fwd, drp;
  int total, bad;
  evg_event_arbiter #(.NREQ(NREQ), .EVENTCODE_WIDTH(8), .FIFO_DEPTH(DEPTH), .NULL_EVENT_CODE(8'h00)) dut (
    .evgTxClk(clk), .evgTxRst_n(rst_n), .reqTDATA(req_d), .reqTVALID(req_v),
    .evgEventTDATA(o_data), .evgEventTVALID(o_valid), .evgEventTREADY(rdy),
    .clearStatus(clr), .overflow(ovf), .eventsForwarded(fwd), .eventsDropped(drp));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    logic        ev;
    logic [7:0]  ed;
    logic [15:0] ef;
  } vec_t;
  vec_t tbl[15];
  logic [7:0] mq[NREQ][$];
  logic m_valid;
  logic [7:0] m_data;
  int m_last, m_fwd, m_drp;
  logic [3:0] m_ovf;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) mq[i].delete();
    m_valid = 1'b0;
    m_data = 8'h00;
    m_last = NREQ - 1;
    m_fwd = 0;
    m_drp = 0;
    m_ovf = 4'h0;
  endtask
  task automatic model_step(input logic [3:0] v, input logic [31:0] d, input logic r, input logic c);
    int sz[NREQ];
    logic popped[NREQ];
    int g, s;
    logic xfer;
    xfer = m_valid && r;
    for (int i = 0; i < NREQ; i++) begin
      sz[i] = mq[i].size();
      popped[i] = 1'b0;
    end
    g = -1;
    if (!m_valid || r)
      for (int k = 1; k <= NREQ; k++) begin
        s = (m_last + k) % NREQ;
        if (g < 0 && sz[s] > 0) g = s;
      end
    if (g >= 0) begin
      m_data = mq[g].pop_front();
      popped[g] = 1'b1;
      m_last = g;
      m_valid = 1'b1;
    end else if (r) m_valid = 1'b0;
    for (int i = 0; i < NREQ; i++)
      if (v[i] && d[i*8 +: 8] != 8'h00) begin
        if (sz[i] < DEPTH || popped[i]) mq[i].push_back(d[i*8 +: 8]);
        else begin
          m_ovf[i] = 1'b1;
          if (m_drp < 65535) m_drp++;
        end
      end
    if (xfer) m_fwd = (m_fwd + 1) % 65536;
    if (c) begin
      m_ovf = 4'h0;
      m_fwd = 0;
      m_drp = 0;
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req_v = '0;
    req_d = '0;
    rdy = 1'b1;
    clr = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask
  initial begin
    logic [7:0] exp_seq[4];
    logic [3:0] rv;
    logic [31:0] rd;
    logic rr, rc;
    total = 0;
    bad = 0;
    tbl[0]  = '{4'b0111, 32'h00302010, 1'b0, 8'h00, 16'd0};
    tbl[1]  = '{4'b0000, 32'h0,        1'b1, 8'h10, 16'd0};
    tbl[2]  = '{4'b0000, 32'h0,        1'b1, 8'h20, 16'd1};
    tbl[3]  = '{4'b0000, 32'h0,        1'b1, 8'h30, 16'd2};
    tbl[4]  = '{4'b0011, 32'h00002111, 1'b0, 8'h00, 16'd3};
    tbl[5]  = '{4'b0000, 32'h0,        1'b1, 8'h11, 16'd3};
    tbl[6]  = '{4'b0000, 32'h0,        1'b1, 8'h21, 16'd4};
    tbl[7]  = '{4'b0000, 32'h0,        1'b0, 8'h00, 16'd5};
    tbl[8]  = '{4'b0010, 32'h00004100, 1'b0, 8'h00, 16'd5};
    tbl[9]  = '{4'b0000, 32'h0,        1'b1, 8'h41, 16'd5};
    tbl[10] = '{4'b1011, 32'h53005150, 1'b0, 8'h00, 16'd6};
    tbl[11] = '{4'b0000, 32'h0,        1'b1, 8'h53, 16'd6};
    tbl[12] = '{4'b0000, 32'h0,        1'b1, 8'h50, 16'd7};
    tbl[13] = '{4'b0000, 32'h0,        1'b1, 8'h51, 16'd8};
    tbl[14] = '{4'b0000, 32'h0,        1'b0, 8'h00, 16'd9};
    do_reset();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_fwd", 32'(fwd), 32'd0);
    check("rst_drp", 32'(drp), 32'd0);
    for (int r = 0; r < 15; r++) begin
      req_v = tbl[r].v;
      req_d = tbl[r].d;
      tick();
      check($sformatf("tbl%0d_valid", r), 32'(o_valid), 32'(tbl[r].ev));
      if (tbl[r].ev) check($sformatf("tbl%0d_data", r), 32'(o_data), 32'(tbl[r].ed));
      check($sformatf("tbl%0d_fwd", r), 32'(fwd), 32'(tbl[r].ef));
    end
    req_v = '0;
    rdy = 1'b0;
    req_v = 4'b0011;
    req_d = 32'h00006261;
    tick();
    req_v = '0;
    repeat (21) tick();
    check("bp_valid", 32'(o_valid), 32'd1);
    check("bp_data", 32'(o_data), 32'h61);
    check("bp_fwd", 32'(fwd), 32'd9);
    rdy = 1'b1;
    tick();
    check("bp_rel_data", 32'(o_data), 32'h62);
    tick();
    check("bp_rel_valid", 32'(o_valid), 32'd0);
    check("bp_rel_fwd", 32'(fwd), 32'd11);
    rdy = 1'b0;
    for (int k = 0; k < 6; k++) begin
      req_v = 4'b1000;
      req_d = {8'(8'h71 + k), 24'h0};
      tick();
    end
    req_v = '0;
    check("ovf_flag", 32'(ovf), 32'h8);
    check("ovf_drp", 32'(drp), 32'd1);
    check("ovf_data", 32'(o_data), 32'h71);
    rdy = 1'b1;
    req_v = 4'b1000;
    req_d = 32'h77000000;
    tick();
    req_v = '0;
    check("poppush_drp", 32'(drp), 32'd1);
    check("poppush_data", 32'(o_data), 32'h72);
    exp_seq[0] = 8'h73;
    exp_seq[1] = 8'h74;
    exp_seq[2] = 8'h75;
    exp_seq[3] = 8'h77;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("drain%0d_data", k), 32'(o_data), 32'(exp_seq[k]));
    end
    tick();
    check("drain_valid", 32'(o_valid), 32'd0);
    check("drain_fwd", 32'(fwd), 32'd17);
    req_v = 4'b0100;
    req_d = 32'h0;
    tick();
    req_v = '0;
    tick();
    check("null_valid", 32'(o_valid), 32'd0);
    check("null_fwd", 32'(fwd), 32'd17);
    check("null_drp", 32'(drp), 32'd1);
    rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req_v = 4'b0100;
      req_d = {8'h0, 8'(8'h81 + k), 16'h0};
      tick();
    end
    req_d = 32'h00860000;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    req_v = '0;
    check("clr_ovf", 32'(ovf), 32'd0);
    check("clr_drp", 32'(drp), 32'd0);
    check("clr_fwd", 32'(fwd), 32'd0);
    check("clr_data", 32'(o_data), 32'h81);
    rdy = 1'b1;
    repeat (4) tick();
    check("clr_drain_data", 32'(o_data), 32'h85);
    tick();
    check("clr_drain_valid", 32'(o_valid), 32'd0);
    check("clr_drain_fwd", 32'(fwd), 32'd5);
    rdy = 1'b0;
    req_v = 4'b1110;
    req_d = 32'h93919200;
    tick();
    req_v = '0;
    tick();
    check("pre_rst_valid", 32'(o_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(o_valid), 32'd0);
    check("async_rst_data", 32'(o_data), 32'd0);
    check("async_rst_fwd", 32'(fwd), 32'd0);
    tick();
    rst_n = 1'b1;
    rdy = 1'b1;
    req_v = 4'b1001;
    req_d = 32'hA30000A0;
    tick();
    req_v = '0;
    tick();
    check("post_rst_first", 32'(o_data), 32'hA0);
    tick();
    check("post_rst_second", 32'(o_data), 32'hA3);
    tick();
    check("post_rst_empty", 32'(o_valid), 32'd0);
    do_reset();
    model_reset();
    for (int c = 0; c < 4000; c++) begin
      rv = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      rd = $urandom;
      if ($urandom_range(0, 7) == 0) rd[7:0] = 8'h00;
      rr = (c % 200 < 120) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      rc = $urandom_range(0, 249) == 0;
      req_v = rv;
      req_d = rd;
      rdy = rr;
      clr = rc;
      model_step(rv, rd, rr, rc);
      tick();
      check("rnd_valid", 32'(o_valid), 32'(m_valid));
      if (m_valid) check("rnd_data", 32'(o_data), 32'(m_data));
      check("rnd_ovf", 32'(ovf), 32'(m_ovf));
      check("rnd_fwd", 32'(fwd), 32'(m_fwd));
      check("rnd_drp", 32'(drp), 32'(m_drp));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/evg_event_arbiter.md
Name: evg_event_arbiter

Overview:
Merges event-code requests from several independent sources (both sequencer RAM banks' outputs, software-injected events, trigger inputs) into the single event stream consumed by the EVG transmitter. Sources issue single-cycle TVALID pulses and cannot be back-pressured, so each source has a small FIFO; a round-robin arbiter drains the FIFOs into one AXI-stream-style output that honours transmitter TREADY. Sits in the evgTxClk domain between the sequencers and the transmitter event-slot logic.

Parameters:
NREQ, 4, number of request sources (2..8)
EVENTCODE_WIDTH, 8, event code width
FIFO_DEPTH, 4, entries per source FIFO (power of two, >=2)
NULL_EVENT_CODE, 8'h00, code that is never enqueued

Ports:
evgTxClk  in  1  transmitter clock; all logic in this domain
evgTxRst_n  in  1  asynchronous active-low reset
reqTDATA  in  NREQ*EVENTCODE_WIDTH  source i code at [i*EVENTCODE_WIDTH+:EVENTCODE_WIDTH]
reqTVALID  in  NREQ  source i request pulse; no ready returned
evgEventTDATA  out  EVENTCODE_WIDTH  arbitrated event code
evgEventTVALID  out  1  output valid
evgEventTREADY  in  1  transmitter accepts event this cycle
clearStatus  in  1  single-cycle pulse: clear overflow flags and counters
overflow  out  NREQ  sticky per-source drop flag
eventsForwarded  out  16  count of accepted output transfers, wraps
eventsDropped  out  16  count of dropped requests (all sources), saturates at 16'hFFFF

Behaviour:
- Reset (async assert, sync deassert assumed upstream): all FIFOs empty, evgEventTVALID=0, evgEventTDATA=0, overflow=0, both counters=0, round-robin pointer=NREQ-1 (so source 0 wins first).
- Enqueue: reqTVALID[i]=1 and code != NULL_EVENT_CODE writes FIFO i at clock edge. NULL code: ignored, not counted.
- Full FIFO i: request dropped, overflow[i] set, eventsDropped +1 (per dropped source; simultaneous drops from k sources add k). Exception: if FIFO i is popped in the same cycle, the push is accepted; no drop.
- Output register loads when (!evgEventTVALID || evgEventTREADY) and some FIFO is non-empty; otherwise holds. TDATA stable while TVALID=1 and TREADY=0.
- Transfer = TVALID && TREADY; eventsForwarded +1 per transfer.
- Arbitration: among non-empty FIFOs, grant first index searching from pointer+1 upward, wrapping modulo NREQ; pointer := granted index on each load. A source that is the only requester is granted every load (back-to-back throughput 1 event/cycle with TREADY held high).
- Latency: request in cycle c with all FIFOs empty and output idle -> evgEventTVALID=1 with that code in cycle c+2.
- Per-source ordering preserved; no ordering guarantee across sources.
- clearStatus: clears overflow and both counters next edge; takes priority over a simultaneous increment/set in that cycle (counter reads 0, flag reads 0). Does not flush FIFOs or output.
- No combinational path from reqTVALID or TREADY to any output.

Test Plan:
- Single source: pulse reqTVALID[0] code 8'h21 at cycle 10, TREADY=1 -> TVALID=1, TDATA=8'h21 at cycle 12 for one cycle; eventsForwarded=1.
- Round-robin: fill sources 0,1,2 with codes 8'h10,8'h20,8'h30 same cycle, TREADY=1 -> output order 10,20,30 on consecutive cycles; next batch after last grant 2 starts at source 0 again.
- Back-pressure: TREADY=0 for 20 cycles with 2 queued events -> TDATA holds first code, no extra transfers; release -> both delivered, count=2.
- Overflow: TREADY=0, 6 pulses on source 3 (depth 4, one already in output register) -> 5 held, overflow[3]=1, eventsDropped=1; simultaneous pop+push at full -> no drop.
- NULL filter/clear: pulse code 8'h00 -> no output, counters unchanged; clearStatus concurrent with a drop -> overflow=0, eventsDropped=0.
- Reset mid-operation: assert evgTxRst_n low with events queued and TVALID=1 -> TVALID=0 immediately (async), all queued events discarded, counters 0; after release first grant goes to source 0.
